gpmc_master: RTL and testbench

GPMC_MASTER -- requirements
Module: gpmc_master

---
 rtl/gpmc_master.sv | 184 ++++++++++++++++++
 tb/tb_gpmc_master.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpmc_master.sv
// GPMC bus master: turns single request/response transactions into
// multiplexed address/data bus cycles (address phase, then write data or
// turnaround + read data, then a one-cycle hold that reports completion).
// All bus strobes are active-low and every output comes straight from a flop.
module gpmc_master #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_CYC   = 2,
  parameter int WR_CYC     = 2,
  parameter int RD_CYC     = 4,
  parameter int TURN_CYC   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [DATA_WIDTH-1:0] gpmc_ad_out,
  output logic                  gpmc_ad_oe,
  input  logic [DATA_WIDTH-1:0] gpmc_ad_in,
  output logic                  gpmc_advn,
  output logic                  gpmc_csn1,
  output logic                  gpmc_wein,
  output logic                  gpmc_oen,
  output logic                  gpmc_clk
);

  // Phase lengths below one cycle would make the down-counter underflow.
  if (ADDR_CYC < 1 || WR_CYC < 1 || RD_CYC < 1 || TURN_CYC < 1) begin : g_bad_param
    $error("gpmc_master: every phase length must be at least one cycle");
  end

  // Counter only needs to hold the longest phase length minus one.
  localparam int MAX_AW  = (ADDR_CYC > WR_CYC) ? ADDR_CYC : WR_CYC;
  localparam int MAX_RT  = (RD_CYC > TURN_CYC) ? RD_CYC : TURN_CYC;
  localparam int MAX_CYC = (MAX_AW > MAX_RT) ? MAX_AW : MAX_RT;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] ADDR_LD = CNT_W'(ADDR_CYC - 1);
  localparam logic [CNT_W-1:0] WR_LD   = CNT_W'(WR_CYC - 1);
  localparam logic [CNT_W-1:0] RD_LD   = CNT_W'(RD_CYC - 1);
  localparam logic [CNT_W-1:0] TURN_LD = CNT_W'(TURN_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    TURN,
    RDATA,
    HOLD
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      phase_cnt;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  // Bus sequencer: state, phase counter, captured request and every output.
  // NOTE: each output is assigned the value it must show in the *next* state,
  // so it changes on the same edge as the state and never passes through
  // combinational logic; all sequential state uses non-blocking assignments.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      phase_cnt   <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      gpmc_ad_out <= '0;
      gpmc_ad_oe  <= 1'b0;
      gpmc_advn   <= 1'b1;
      gpmc_csn1   <= 1'b1;
      gpmc_wein   <= 1'b1;
      gpmc_oen    <= 1'b1;
      gpmc_clk    <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      // The bus clock runs for the whole chip-select window; IDLE entry and
      // ADDR entry override this below.
      if (state != IDLE) begin
        gpmc_clk <= ~gpmc_clk;
      end

      case (state)
        IDLE: begin
          if (req_valid) begin
            state       <= ADDR;
            phase_cnt   <= ADDR_LD;
            write_q     <= req_write;
            wdata_q     <= req_wdata;
            req_ready   <= 1'b0;
            gpmc_csn1   <= 1'b0;
            gpmc_advn   <= 1'b0;
            gpmc_ad_oe  <= 1'b1;
            gpmc_ad_out <= DATA_WIDTH'(req_addr);
            gpmc_clk    <= 1'b1;
          end
        end

        ADDR: begin
          if (phase_cnt != '0) begin
            phase_cnt <= phase_cnt - 1'b1;
          end else if (write_q) begin
            state       <= WDATA;
            phase_cnt   <= WR_LD;
            gpmc_advn   <= 1'b1;
            gpmc_wein   <= 1'b0;
            gpmc_ad_out <= wdata_q;
          end else begin
            // Release the AD bus one phase before the target may drive it.
            state      <= TURN;
            phase_cnt  <= TURN_LD;
            gpmc_advn  <= 1'b1;
            gpmc_ad_oe <= 1'b0;
          end
        end

        WDATA: begin
          if (phase_cnt != '0) begin
            phase_cnt <= phase_cnt - 1'b1;
          end else begin
            state     <= HOLD;
            phase_cnt <= '0;
            gpmc_wein <= 1'b1;
            rsp_valid <= 1'b1;
          end
        end

        TURN: begin
          if (phase_cnt != '0) begin
            phase_cnt <= phase_cnt - 1'b1;
          end else begin
            state     <= RDATA;
            phase_cnt <= RD_LD;
            gpmc_oen  <= 1'b0;
          end
        end

        RDATA: begin
          if (phase_cnt != '0) begin
            phase_cnt <= phase_cnt - 1'b1;
          end else begin
            // Target data is only guaranteed settled at the end of the phase.
            state     <= HOLD;
            phase_cnt <= '0;
            rsp_rdata <= gpmc_ad_in;
            gpmc_oen  <= 1'b1;
            rsp_valid <= 1'b1;
          end
        end

        HOLD: begin
          state       <= IDLE;
          phase_cnt   <= '0;
          req_ready   <= 1'b1;
          gpmc_csn1   <= 1'b1;
          gpmc_ad_oe  <= 1'b0;
          gpmc_ad_out <= '0;
          gpmc_clk    <= 1'b0;
        end

        default: begin
          state       <= IDLE;
          phase_cnt   <= '0;
          req_ready   <= 1'b1;
          gpmc_csn1   <= 1'b1;
          gpmc_advn   <= 1'b1;
          gpmc_wein   <= 1'b1;
          gpmc_oen    <= 1'b1;
          gpmc_ad_oe  <= 1'b0;
          gpmc_ad_out <= '0;
          gpmc_clk    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpmc_master.sv
// Self-checking bench for gpmc_master: a driver pushes expected transactions
// into a scoreboard queue, a bus monitor plus a small target model check every
// bus cycle and pop the queue on each completion pulse.  A second instance
// with short phases checks single-cycle read sampling.
module tb_gpmc_master;

  localparam int A_CYC = 2;
  localparam int W_CYC = 2;
  localparam int R_CYC = 4;
  localparam int T_CYC = 1;

  typedef struct {
    logic        write;
    logic [3:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } txn_t;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [3:0]  req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic [15:0] gpmc_ad_out;
  logic        gpmc_ad_oe;
  logic [15:0] gpmc_ad_in;
  logic        gpmc_advn;
  logic        gpmc_csn1;
  logic        gpmc_wein;
  logic        gpmc_oen;
  logic        gpmc_clk;

  logic        f_req_valid;
  logic        f_req_ready;
  logic        f_req_write;
  logic [3:0]  f_req_addr;
  logic [15:0] f_req_wdata;
  logic        f_rsp_valid;
  logic [15:0] f_rsp_rdata;
  logic [15:0] f_ad_out;
  logic        f_ad_oe;
  logic [15:0] f_ad_in;
  logic        f_advn;
  logic        f_csn1;
  logic        f_wein;
  logic        f_oen;
  logic        f_gclk;
  logic [15:0] f_data;

  int total = 0;
  int bad   = 0;

  txn_t        q[$];
  logic [15:0] ref_mem   [16];
  logic [15:0] slave_mem [16];
  logic [3:0]  lat_addr;
  logic [15:0] ad_in_drv;
  logic [15:0] exp_hold;
  logic        chk_gap;

  gpmc_master #(
    .ADDR_WIDTH(4), .DATA_WIDTH(16),
    .ADDR_CYC(A_CYC), .WR_CYC(W_CYC), .RD_CYC(R_CYC), .TURN_CYC(T_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .gpmc_ad_out(gpmc_ad_out), .gpmc_ad_oe(gpmc_ad_oe), .gpmc_ad_in(gpmc_ad_in),
    .gpmc_advn(gpmc_advn), .gpmc_csn1(gpmc_csn1), .gpmc_wein(gpmc_wein),
    .gpmc_oen(gpmc_oen), .gpmc_clk(gpmc_clk)
  );

  gpmc_master #(
    .ADDR_WIDTH(4), .DATA_WIDTH(16),
    .ADDR_CYC(1), .WR_CYC(2), .RD_CYC(1), .TURN_CYC(1)
  ) dut_fast (
    .clk(clk), .rst_n(rst_n),
    .req_valid(f_req_valid), .req_ready(f_req_ready), .req_write(f_req_write),
    .req_addr(f_req_addr), .req_wdata(f_req_wdata),
    .rsp_valid(f_rsp_valid), .rsp_rdata(f_rsp_rdata),
    .gpmc_ad_out(f_ad_out), .gpmc_ad_oe(f_ad_oe), .gpmc_ad_in(f_ad_in),
    .gpmc_advn(f_advn), .gpmc_csn1(f_csn1), .gpmc_wein(f_wein),
    .gpmc_oen(f_oen), .gpmc_clk(f_gclk)
  );

  assign gpmc_ad_in = ad_in_drv;
  // Fast target drives the wrong value whenever the read strobe is inactive.
  assign f_ad_in    = f_oen ? ~f_data : f_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Bus monitor and target model, sampled 1 time unit after each rising edge.
  initial begin
    int   csn_len, advn_cnt, wein_cnt, oen_cnt, gap;
    logic hold_seen;
    txn_t cur;
    csn_len = 0; advn_cnt = 0; wein_cnt = 0; oen_cnt = 0; gap = 0;
    hold_seen = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        check("rst_csn", gpmc_csn1, 1);
        check("rst_oe", gpmc_ad_oe, 0);
        check("rst_ready", req_ready, 1);
        check("rst_rsp", rsp_valid, 0);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_strobes", {gpmc_advn, gpmc_wein, gpmc_oen, gpmc_clk}, 4'b1110);
        csn_len = 0; advn_cnt = 0; wein_cnt = 0; oen_cnt = 0; gap = 0;
        hold_seen = 1'b0;
        exp_hold  = 16'h0;
        ad_in_drv = 16'hDEAD;
      end else begin
        check("oe_vs_oen", gpmc_ad_oe && !gpmc_oen, 0);
        if (hold_seen) begin
          check("csn_release", gpmc_csn1, 1);
          hold_seen = 1'b0;
        end
        if (gpmc_csn1) begin
          check("clk_idle", gpmc_clk, 0);
          check("ready_idle", req_ready, 1);
          check("rsp_outside_txn", rsp_valid, 0);
          check("idle_oe", gpmc_ad_oe, 0);
          gap++;
          csn_len = 0; advn_cnt = 0; wein_cnt = 0; oen_cnt = 0;
          ad_in_drv = 16'hDEAD;
        end else begin
          if (csn_len == 0) begin
            if (chk_gap) check("b2b_gap", gap, 1);
            gap = 0;
          end
          check("gclk_toggle", gpmc_clk, 32'(csn_len[0] == 1'b0));
          check("ready_busy", req_ready, 0);
          csn_len++;
          if (q.size() == 0) begin
            check("bus_without_req", q.size(), 1);
          end else begin
            cur = q[0];
            if (!gpmc_advn) begin
              advn_cnt++;
              check("addr_ad", gpmc_ad_out, 32'(cur.addr));
              check("addr_oe", gpmc_ad_oe, 1);
              lat_addr = gpmc_ad_out[3:0];
            end else if (!cur.write) begin
              check("read_oe_off", gpmc_ad_oe, 0);
            end
            if (!gpmc_wein) begin
              wein_cnt++;
              check("wdata_ad", gpmc_ad_out, cur.wdata);
              check("wdata_oe", gpmc_ad_oe, 1);
              slave_mem[lat_addr] = gpmc_ad_out;
            end
            if (!gpmc_oen) begin
              oen_cnt++;
              ad_in_drv = (oen_cnt == R_CYC) ? slave_mem[lat_addr] : ~slave_mem[lat_addr];
            end else begin
              ad_in_drv = 16'hDEAD;
            end
            if (rsp_valid) begin
              check("occupancy", csn_len, cur.write ? (A_CYC + W_CYC + 1) : (A_CYC + T_CYC + R_CYC + 1));
              check("advn_len", advn_cnt, A_CYC);
              check("wein_len", wein_cnt, cur.write ? W_CYC : 0);
              check("oen_len", oen_cnt, cur.write ? 0 : R_CYC);
              check("hold_oe", gpmc_ad_oe, 32'(cur.write));
              check("hold_strobes", {gpmc_advn, gpmc_wein, gpmc_oen}, 3'b111);
              if (!cur.write) begin
                check("rdata", rsp_rdata, cur.rdata);
                exp_hold = cur.rdata;
              end
              q.delete(0);
              hold_seen = 1'b1;
            end
          end
        end
        check("rdata_hold", rsp_rdata, exp_hold);
      end
    end
  end

  // Present one request and wait (bounded) for acceptance; leaves req_valid
  // high so a following call runs back-to-back.
  task automatic send(input logic w, input logic [3:0] a, input logic [15:0] d);
    txn_t t;
    int   n;
    req_write = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check("accept_timeout", req_ready, 1);
    end else begin
      t.write = w; t.addr = a; t.wdata = d; t.rdata = ref_mem[a];
      if (w) ref_mem[a] = d;
      q.push_back(t);
      @(negedge clk);
      // Scramble the request fields: the master must use its captured copy.
      req_write = 1'($urandom);
      req_addr  = 4'($urandom);
      req_wdata = 16'($urandom);
    end
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int n;
    req_valid = 1'b0;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) check("drain_timeout", q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  // Read on the short-phase instance: 4-cycle occupancy, single-cycle sample.
  task automatic fast_read(input logic [3:0] a, input logic [15:0] d);
    int   len, oen_n, n;
    logic got;
    f_req_addr = a; f_data = d; f_req_valid = 1'b1;
    n = 0;
    while (!f_req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    f_req_valid = 1'b0;
    f_req_addr  = ~a;
    len = 0; oen_n = 0; got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (!f_csn1) len++;
      if (!f_advn) check("f_addr", f_ad_out, 32'(a));
      check("f_oe_vs_oen", f_ad_oe && !f_oen, 0);
      check("f_wein", f_wein, 1);
      if (!f_oen) oen_n++;
      if (f_rsp_valid) begin
        got = 1'b1;
        check("f_occupancy", len, 4);
        check("f_oen_len", oen_n, 1);
        check("f_rdata", f_rsp_rdata, d);
      end else begin
        @(negedge clk);
      end
    end
    if (!got) check("f_rsp_timeout", got, 1);
    @(negedge clk);
    check("f_idle", {f_csn1, f_gclk, f_req_ready}, 3'b101);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      ref_mem[i]   = 16'hA000 + 16'(i * 16'h0111);
      slave_mem[i] = 16'hA000 + 16'(i * 16'h0111);
    end
    ref_mem[5]   = 16'hBEEF;
    slave_mem[5] = 16'hBEEF;
    lat_addr  = 4'h0;
    ad_in_drv = 16'hDEAD;
    exp_hold  = 16'h0;
    chk_gap   = 1'b0;
    rst_n     = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 4'h0; req_wdata = 16'h0;
    f_req_valid = 1'b0; f_req_write = 1'b0; f_req_addr = 4'h0;
    f_req_wdata = 16'h0; f_data = 16'h0;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single write, then single read of a preloaded location.
    send(1'b1, 4'd3, 16'h1234);
    idle(3);
    send(1'b0, 4'd5, 16'h0000);
    drain();

    // Back-to-back with req_valid held high; read-after-write of addr 7.
    send(1'b1, 4'd7, 16'hCAFE);
    chk_gap = 1'b1;
    send(1'b0, 4'd7, 16'h0000);
    send(1'b0, 4'd5, 16'h0000);
    drain();
    chk_gap = 1'b0;

    // Reset asserted in the third chip-select cycle of a write: abort.
    send(1'b1, 4'd9, 16'h5A5A);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    q.delete(q.size() - 1);
    @(negedge clk);
    rst_n = 1'b1;
    idle(4);

    // A request held during reset must not start a transaction.
    rst_n = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd2; req_wdata = 16'h7777;
    repeat (3) @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b1;
    idle(3);

    // Random traffic, some back-to-back, some with idle gaps.
    for (int i = 0; i < 30; i++) begin
      send(1'($urandom), 4'($urandom), 16'($urandom));
      if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 3));
    end
    drain();

    // Short-phase instance.
    fast_read(4'd6, 16'h1357);
    fast_read(4'd1, 16'hF00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
